// File: rtl/stream_deserializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_deserializer_if: narrow-in / wide-out valid-ready bundle       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface stream_deserializer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  logic                  s_valid;
  logic                  s_ready;
  logic [IN_W-1:0]       s_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [IN_W*RATIO-1:0] m_data;
  logic [RATIO-1:0]      m_keep;
  logic                  m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );
endinterface
`default_nettype wire

// File: rtl/stream_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_deserializer: packs RATIO narrow beats into one wide word      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module stream_deserializer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int CNT_W = $clog2(RATIO)
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  stream_deserializer_if.slave bus,
  output logic [15:0]          word_cnt
);

  logic [CNT_W-1:0]            r_cnt;
  logic [RATIO-1:0][IN_W-1:0]  r_buf;
  logic                        r_m_valid;
  logic [RATIO-1:0][IN_W-1:0]  r_m_data;
  logic [RATIO-1:0]            r_m_keep;
  logic                        r_m_last;
  logic [15:0]                 r_word_cnt;

  logic                        w_s_ready;
  logic                        w_s_fire;
  logic                        w_m_fire;
  logic                        w_complete;
  logic [RATIO-1:0][IN_W-1:0]  w_word;
  logic [RATIO-1:0]            w_keep;

  assign w_s_ready  = !r_m_valid || bus.m_ready;
  assign w_s_fire   = bus.s_valid && w_s_ready;
  assign w_m_fire   = r_m_valid && bus.m_ready;
  assign w_complete = w_s_fire && ((r_cnt == CNT_W'(RATIO-1)) || bus.s_last);

  // Lanes above the current one are already zero because the buffer is
  // cleared whenever a word completes.
  always_comb begin
    w_word = r_buf;
    w_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k == int'(r_cnt)) w_word[k] = bus.s_data;
      w_keep[k] = (k <= int'(r_cnt));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_buf      <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_keep   <= '0;
      r_m_last   <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (w_m_fire) r_word_cnt <= r_word_cnt + 16'd1;
      if (w_complete) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_word;
        r_m_keep  <= w_keep;
        r_m_last  <= bus.s_last;
        r_cnt     <= '0;
        r_buf     <= '0;
      end else begin
        if (w_m_fire) r_m_valid <= 1'b0;
        if (w_s_fire) begin
          r_buf[r_cnt] <= bus.s_data;
          r_cnt        <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_keep  = r_m_keep;
  assign bus.m_last  = r_m_last;
  assign word_cnt    = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stream_deserializer: randomized bench with a queue-based model     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_stream_deserializer;
  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OW    = IN_W * RATIO;

  typedef struct packed {
    logic             last;
    logic [RATIO-1:0] keep;
    logic [OW-1:0]    data;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] word_cnt;

  stream_deserializer_if #(.IN_W(IN_W), .RATIO(RATIO)) bus ();

  stream_deserializer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ready_err = 0;
  int timeouts = 0;
  int n_hs = 0;
  logic [IN_W-1:0] cur_q[$];
  word_t exp_q[$];
  word_t obs_q[$];

  // Reference model: gather accepted beats, emit a word at RATIO beats or on last
  task automatic model_beat(input logic [IN_W-1:0] d, input logic last);
    word_t w;
    cur_q.push_back(d);
    if (cur_q.size() == RATIO || last) begin
      w.data = '0;
      for (int k = 0; k < cur_q.size(); k++) w.data[k*IN_W +: IN_W] = cur_q[k];
      w.keep = RATIO'((1 << cur_q.size()) - 1);
      w.last = last;
      exp_q.push_back(w);
      cur_q.delete();
    end
  endtask

  // Inputs change at posedge+1; handshakes are judged at the negedge before the edge
  task automatic cycle();
    @(negedge clk);
    if (bus.s_ready !== (!bus.m_valid || bus.m_ready)) ready_err++;
    if (rst_n && bus.m_valid && bus.m_ready) begin
      obs_q.push_back({bus.m_last, bus.m_keep, bus.m_data});
      n_hs++;
    end
    if (rst_n && bus.s_valid && bus.s_ready) model_beat(bus.s_data, bus.s_last);
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
    logic fired;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    fired = 1'b0;
    for (int n = 0; n < 200 && !fired; n++) begin
      fired = bus.s_ready;
      cycle();
    end
    if (!fired) timeouts++;
    bus.s_valid = 1'b0;
    bus.s_data  = 'x;
    bus.s_last  = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    for (int n = 0; n < cycles; n++) cycle();
    rst_n = 1'b1;
    cur_q.delete();
    exp_q.delete();
    obs_q.delete();
    n_hs = 0;
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0; bus.s_data = 'x; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    apply_reset(3);
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
    total++; if (bus.m_data !== '0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", bus.m_data); end
    total++; if (bus.m_keep !== '0 || bus.m_last !== 1'b0) begin bad++; $display("FAIL reset_keep_last got=%b/%b exp=0000/0", bus.m_keep, bus.m_last); end
    total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", bus.s_ready); end
  endtask

  task automatic test_basic();
    bus.m_ready = 1'b1;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", bus.m_valid); end
    send_beat(8'h44, 1'b1);
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", bus.m_valid); end
    total++; if (bus.m_data !== 32'h44332211) begin bad++; $display("FAIL basic_data got=%h exp=44332211", bus.m_data); end
    total++; if (bus.m_keep !== 4'b1111 || bus.m_last !== 1'b1) begin bad++; $display("FAIL basic_keep_last got=%b/%b exp=1111/1", bus.m_keep, bus.m_last); end
    cycle();
    total++; if (word_cnt !== 16'd1 || bus.m_valid !== 1'b0) begin bad++; $display("FAIL basic_cnt got=%0d/%b exp=1/0", word_cnt, bus.m_valid); end
  endtask

  task automatic test_short();
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    total++; if (bus.m_data !== 32'h0000BBAA || bus.m_keep !== 4'b0011 || bus.m_last !== 1'b1) begin
      bad++; $display("FAIL short_word got=%h/%b/%b exp=0000bbaa/0011/1", bus.m_data, bus.m_keep, bus.m_last); end
    cycle();
    send_beat(8'h5C, 1'b1);
    total++; if (bus.m_data !== 32'h0000005C || bus.m_keep !== 4'b0001 || bus.m_last !== 1'b1) begin
      bad++; $display("FAIL short_lane0 got=%h/%b/%b exp=0000005c/0001/1", bus.m_data, bus.m_keep, bus.m_last); end
    cycle();
    total++; if (word_cnt !== 16'd3) begin bad++; $display("FAIL short_cnt got=%0d exp=3", word_cnt); end
  endtask

  task automatic test_backpressure();
    int stall_bad = 0;
    exp_q.delete(); obs_q.delete();
    bus.m_ready = 1'b0;
    send_beat(8'hA0, 1'b0); send_beat(8'hA1, 1'b0);
    send_beat(8'hA2, 1'b0); send_beat(8'hA3, 1'b1);
    bus.s_valid = 1'b1; bus.s_data = 8'h99; bus.s_last = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_data !== 32'hA3A2A1A0 ||
          bus.m_keep !== 4'b1111 || bus.m_last !== 1'b1) stall_bad++;
      cycle();
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall got=%0d bad cycles exp=0", stall_bad); end
    bus.m_ready = 1'b1;
    #1;
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", bus.s_ready); end
    cycle();
    bus.s_valid = 1'b0; bus.s_data = 'x;
    send_beat(8'h9A, 1'b0); send_beat(8'h9B, 1'b0); send_beat(8'h9C, 1'b1);
    cycle();
    total++; if (obs_q.size() != 2 || exp_q.size() != 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1] || obs_q[1].data !== 32'h9C9B9A99) begin
        bad++; $display("FAIL bp_words got=%h,%h exp=%h,%h", obs_q[0], obs_q[1], exp_q[0], exp_q[1]); end
    end
  endtask

  task automatic test_streaming();
    int pat_bad = 0;
    int cmp_bad = 0;
    exp_q.delete(); obs_q.delete();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = IN_W'($urandom);
      bus.s_last  = (i % 8 == 7);
      if (bus.s_ready !== 1'b1) pat_bad++;
      cycle();
      if (bus.m_valid !== (i % 4 == 3)) pat_bad++;
    end
    bus.s_valid = 1'b0; bus.s_data = 'x; bus.s_last = 1'b0;
    cycle();
    total++; if (pat_bad != 0) begin bad++; $display("FAIL stream_timing got=%0d bad cycles exp=0", pat_bad); end
    total++; if (obs_q.size() != 16 || exp_q.size() != 16) begin bad++; $display("FAIL stream_count got=%0d exp=16", obs_q.size()); end
    else begin
      for (int w = 0; w < 16; w++)
        if (obs_q[w] !== exp_q[w] || obs_q[w].keep !== 4'b1111 || obs_q[w].last !== (w % 2 == 1)) cmp_bad++;
      total++; if (cmp_bad != 0) begin bad++; $display("FAIL stream_words got=%0d wrong exp=0", cmp_bad); end
    end
  endtask

  task automatic test_reset_mid();
    bus.m_ready = 1'b0;
    send_beat(8'hE0, 1'b0); send_beat(8'hE1, 1'b0);
    send_beat(8'hE2, 1'b0); send_beat(8'hE3, 1'b1);
    apply_reset(1);
    total++; if (bus.m_valid !== 1'b0 || word_cnt !== 16'd0) begin bad++; $display("FAIL rst_pending got=%b/%0d exp=0/0", bus.m_valid, word_cnt); end
    bus.m_ready = 1'b1;
    send_beat(8'hF0, 1'b0); send_beat(8'hF1, 1'b0);
    apply_reset(1);
    total++; if (bus.m_valid !== 1'b0 || word_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid got=%b/%0d exp=0/0", bus.m_valid, word_cnt); end
    send_beat(8'h01, 1'b0); send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0); send_beat(8'h04, 1'b0);
    total++; if (bus.m_data !== 32'h04030201 || bus.m_keep !== 4'b1111 || bus.m_last !== 1'b0) begin
      bad++; $display("FAIL rst_residue got=%h/%b/%b exp=04030201/1111/0", bus.m_data, bus.m_keep, bus.m_last); end
    cycle();
  endtask

  task automatic test_wrap();
    int bubbles = 0;
    int cmp_bad = 0;
    apply_reset(1);
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_last  = 1'b1;
    for (int n = 0; n < 70000 && n_hs < 65536; n++) begin
      bus.s_data = IN_W'($urandom);
      cycle();
      if (n_hs > 0 && bus.m_valid !== 1'b1) bubbles++;
    end
    bus.s_valid = 1'b0; bus.s_data = 'x; bus.s_last = 1'b0;
    total++; if (n_hs != 65536) begin bad++; $display("FAIL wrap_timeout got=%0d exp=65536", n_hs); end
    total++; if (word_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", word_cnt); end
    total++; if (bubbles != 0) begin bad++; $display("FAIL wrap_bubbles got=%0d exp=0", bubbles); end
    if (exp_q.size() < obs_q.size()) cmp_bad++;
    else for (int w = 0; w < obs_q.size(); w++) if (obs_q[w] !== exp_q[w]) cmp_bad++;
    total++; if (cmp_bad != 0) begin bad++; $display("FAIL wrap_words got=%0d wrong exp=0", cmp_bad); end
    cycle();
    total++; if (word_cnt !== 16'h0001 || bus.m_valid !== 1'b0) begin bad++; $display("FAIL wrap_next got=%h/%b exp=0001/0", word_cnt, bus.m_valid); end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 'x;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_short();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    test_wrap();
    total++; if (ready_err != 0) begin bad++; $display("FAIL s_ready_rule got=%0d bad cycles exp=0", ready_err); end
    total++; if (timeouts != 0) begin bad++; $display("FAIL beat_timeout got=%0d exp=0", timeouts); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
